apu_core_dispatcher: RTL and testbench

- Core-side initiator for the shared APU interconnect.
- Takes decoded APU instructions from the core pipeline and issues them with a req/gnt handshake to the shared FP/DSP units.
- Tracks outstanding operations and guarantees in-order result return by never mixing latency classes in flight.
- Stalls on register hazards and writes results and FP status flags back to the core register file.

---
 rtl/apu_cluster_package.sv | 40 ++++
 rtl/apu_tag_fifo.sv | 71 +++++++
 rtl/apu_core_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_apu_core_dispatcher.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// Shared definitions for the APU cluster: unit-type encoding, pipeline
// depths of the fixed-latency units and the latency-class mapping used by
// the core-side dispatcher.
package apu_cluster_package;

  // Unit-type encoding carried on apu_type.
  localparam logic [2:0] APU_TYPE_DSP_MULT = 3'd0;
  localparam logic [2:0] APU_TYPE_INT_MULT = 3'd1;
  localparam logic [2:0] APU_TYPE_INT_DIV  = 3'd2;
  localparam logic [2:0] APU_TYPE_ADDSUB   = 3'd3;
  localparam logic [2:0] APU_TYPE_MULT     = 3'd4;
  localparam logic [2:0] APU_TYPE_MAC      = 3'd5;
  localparam logic [2:0] APU_TYPE_CAST     = 3'd6;
  localparam logic [2:0] APU_TYPE_DIVSQRT  = 3'd7;

  // Pipeline depth of each fixed-latency shared unit.
  localparam int C_DSP_PIPE_REGS    = 2;
  localparam int C_ADDSUB_PIPE_REGS = 1;
  localparam int C_MULT_PIPE_REGS   = 2;
  localparam int C_MAC_PIPE_REGS    = 3;
  localparam int C_CAST_PIPE_REGS   = 1;

  // Latency class: the pipe-regs count for fixed-latency units, or the
  // ITER sentinel for the iterative (variable latency) units.
  typedef logic [3:0] lat_class_t;
  localparam lat_class_t C_LAT_ITER = 4'hF;

  function automatic lat_class_t lat_class(input logic [2:0] apu_type);
    case (apu_type)
      APU_TYPE_DSP_MULT,
      APU_TYPE_INT_MULT: lat_class = lat_class_t'(C_DSP_PIPE_REGS);
      APU_TYPE_ADDSUB:   lat_class = lat_class_t'(C_ADDSUB_PIPE_REGS);
      APU_TYPE_MULT:     lat_class = lat_class_t'(C_MULT_PIPE_REGS);
      APU_TYPE_MAC:      lat_class = lat_class_t'(C_MAC_PIPE_REGS);
      APU_TYPE_CAST:     lat_class = lat_class_t'(C_CAST_PIPE_REGS);
      default:           lat_class = C_LAT_ITER;  // INT_DIV, DIVSQRT
    endcase
  endfunction

endpackage

// File: rtl/apu_tag_fifo.sv
// Tag FIFO holding the destination register of every in-flight APU
// operation. Exposes all entries and their valid bits so the dispatcher
// can compare incoming registers against pending writes.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module apu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [DEPTH-1:0]            o_entry_valid,
  output logic [DEPTH-1:0][WIDTH-1:0] o_entries
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [CNT_W-1:0]            r_count;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;

  logic w_push;
  logic w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop)  r_valid[r_rd_ptr] <= 1'b0;
      if (w_push) r_valid[r_wr_ptr] <= 1'b1;
    end
  end

  // Tag storage.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is deliberately not reset; r_valid says which entries
    // mean anything, so stale contents are never observed.
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_full        = (r_count == CNT_W'(DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_entry_valid = r_valid;
  assign o_entries     = r_mem;

endmodule

// File: rtl/apu_core_dispatcher.sv
// Core-side initiator for the shared APU interconnect. Issues decoded APU
// instructions with req/gnt, keeps only one latency class in flight so
// results return in order, stalls on register hazards and writes results
// and FP flags back one cycle after each result arrives.
module apu_core_dispatcher
  import apu_cluster_package::*;
#(
  parameter int NR_OUTSTANDING = 4,
  parameter int WAPUTYPE       = 3,
  parameter int WOP            = 3,
  parameter int NDSFLAGS       = 15,
  parameter int NUSFLAGS       = 5,
  parameter int WREGADDR       = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic [WAPUTYPE-1:0]          apu_type_i,
  input  logic [WOP-1:0]               apu_op_i,
  input  logic [2:0][31:0]             apu_operands_i,
  input  logic [NDSFLAGS-1:0]          apu_flags_i,
  input  logic [WREGADDR-1:0]          apu_waddr_i,
  input  logic [2:0][WREGADDR-1:0]     apu_read_regs_i,
  input  logic [2:0]                   apu_read_regs_valid_i,
  output logic                         stall_o,
  output logic                         apu_master_req_o,
  input  logic                         apu_master_gnt_i,
  output logic [WAPUTYPE-1:0]          apu_master_type_o,
  output logic [WOP-1:0]               apu_master_op_o,
  output logic [2:0][31:0]             apu_master_operands_o,
  output logic [NDSFLAGS-1:0]          apu_master_flags_o,
  input  logic                         apu_master_valid_i,
  input  logic [31:0]                  apu_master_result_i,
  input  logic [NUSFLAGS-1:0]          apu_master_flags_i,
  output logic                         wb_valid_o,
  output logic [WREGADDR-1:0]          wb_waddr_o,
  output logic [31:0]                  wb_result_o,
  output logic                         fflags_we_o,
  output logic [NUSFLAGS-1:0]          fflags_o,
  output logic                         busy_o,
  output logic                         protocol_err_o
);

  // True when a pending write to 'pend' collides with the destination or
  // with any valid source of the instruction waiting at decode.
  function automatic logic reg_clash(
    input logic [WREGADDR-1:0]      pend,
    input logic [WREGADDR-1:0]      waddr,
    input logic [2:0][WREGADDR-1:0] srcs,
    input logic [2:0]               srcs_v
  );
    reg_clash = (pend == waddr);
    for (int s = 0; s < 3; s++) begin
      if (srcs_v[s] && (srcs[s] == pend)) reg_clash = 1'b1;
    end
  endfunction

  logic [WREGADDR-1:0]                     w_head;
  logic                                    w_full;
  logic                                    w_empty;
  logic [NR_OUTSTANDING-1:0]               w_entry_valid;
  logic [NR_OUTSTANDING-1:0][WREGADDR-1:0] w_entries;

  lat_class_t w_class;
  logic       w_hazard;
  logic       w_class_ok;
  logic       w_can_issue;
  logic       w_issue;
  logic       w_retire;

  lat_class_t          r_class;
  logic                r_wb_valid;
  logic [WREGADDR-1:0] r_wb_waddr;
  logic [31:0]         r_wb_result;
  logic [NUSFLAGS-1:0] r_fflags;
  logic                r_protocol_err;

  apu_tag_fifo #(
    .DEPTH (NR_OUTSTANDING),
    .WIDTH (WREGADDR)
  ) u_tag_fifo (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_push        (w_issue),
    .i_data        (apu_waddr_i),
    .i_pop         (w_retire),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_entry_valid (w_entry_valid),
    .o_entries     (w_entries)
  );

  // Register hazard against every in-flight destination and the pending writeback.
  always_comb begin
    // NOTE: default first so no path leaves w_hazard unassigned (no latch).
    w_hazard = 1'b0;
    for (int e = 0; e < NR_OUTSTANDING; e++) begin
      if (w_entry_valid[e] &&
          reg_clash(w_entries[e], apu_waddr_i, apu_read_regs_i, apu_read_regs_valid_i))
        w_hazard = 1'b1;
    end
    if (r_wb_valid &&
        reg_clash(r_wb_waddr, apu_waddr_i, apu_read_regs_i, apu_read_regs_valid_i))
      w_hazard = 1'b1;
  end

  // Only one latency class may be in flight, and an iterative op runs alone.
  // The full check uses the pre-pop occupancy: no bypass of a same-cycle retire.
  assign w_class     = lat_class(apu_type_i[2:0]);
  assign w_class_ok  = w_empty | ((w_class == r_class) & (r_class != C_LAT_ITER));
  assign w_can_issue = rst_ni & ~w_hazard & ~w_full & w_class_ok;

  assign apu_master_req_o = enable_i & w_can_issue;
  assign stall_o          = enable_i & ~(apu_master_req_o & apu_master_gnt_i);
  assign w_issue          = apu_master_req_o & apu_master_gnt_i;
  assign w_retire         = rst_ni & apu_master_valid_i & ~w_empty;

  assign apu_master_type_o     = apu_type_i;
  assign apu_master_op_o       = apu_op_i;
  assign apu_master_operands_o = apu_operands_i;
  assign apu_master_flags_o    = apu_flags_i;

  // Latency class of the operations currently in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      r_class <= '0;
    else if (w_issue) r_class <= w_class;
  end

  // Writeback and FP-flag update, registered one cycle after a result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wb_valid  <= 1'b0;
      r_wb_waddr  <= '0;
      r_wb_result <= '0;
      r_fflags    <= '0;
    end else begin
      r_wb_valid <= w_retire;
      if (w_retire) begin
        r_wb_waddr  <= w_head;
        r_wb_result <= apu_master_result_i;
        r_fflags    <= apu_master_flags_i;
      end
    end
  end

  // Sticky error for a result arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                            r_protocol_err <= 1'b0;
    else if (apu_master_valid_i && w_empty) r_protocol_err <= 1'b1;
  end

  assign wb_valid_o     = r_wb_valid;
  assign wb_waddr_o     = r_wb_waddr;
  assign wb_result_o    = r_wb_result;
  assign fflags_we_o    = r_wb_valid;
  assign fflags_o       = r_fflags;
  assign busy_o         = ~w_empty | r_wb_valid;
  assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_apu_core_dispatcher.sv
// Self-checking bench for apu_core_dispatcher: directed cycle tables for
// the ordering, hazard, full-FIFO, protocol-error and reset corners, then
// a randomized run against a queue-based reference model.
module tb_apu_core_dispatcher;
  import apu_cluster_package::*;

  localparam int N      = 4;
  localparam int T_ADD  = 3;
  localparam int T_MUL  = 4;
  localparam int T_MAC  = 5;
  localparam int T_DIV  = 7;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             enable_i;
  logic [2:0]       apu_type_i;
  logic [2:0]       apu_op_i;
  logic [2:0][31:0] apu_operands_i;
  logic [14:0]      apu_flags_i;
  logic [5:0]       apu_waddr_i;
  logic [2:0][5:0]  apu_read_regs_i;
  logic [2:0]       apu_read_regs_valid_i;
  logic             stall_o;
  logic             apu_master_req_o;
  logic             apu_master_gnt_i;
  logic [2:0]       apu_master_type_o;
  logic [2:0]       apu_master_op_o;
  logic [2:0][31:0] apu_master_operands_o;
  logic [14:0]      apu_master_flags_o;
  logic             apu_master_valid_i;
  logic [31:0]      apu_master_result_i;
  logic [4:0]       apu_master_flags_i;
  logic             wb_valid_o;
  logic [5:0]       wb_waddr_o;
  logic [31:0]      wb_result_o;
  logic             fflags_we_o;
  logic [4:0]       fflags_o;
  logic             busy_o;
  logic             protocol_err_o;

  always #5 clk_i = ~clk_i;

  apu_core_dispatcher dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .enable_i              (enable_i),
    .apu_type_i            (apu_type_i),
    .apu_op_i              (apu_op_i),
    .apu_operands_i        (apu_operands_i),
    .apu_flags_i           (apu_flags_i),
    .apu_waddr_i           (apu_waddr_i),
    .apu_read_regs_i       (apu_read_regs_i),
    .apu_read_regs_valid_i (apu_read_regs_valid_i),
    .stall_o               (stall_o),
    .apu_master_req_o      (apu_master_req_o),
    .apu_master_gnt_i      (apu_master_gnt_i),
    .apu_master_type_o     (apu_master_type_o),
    .apu_master_op_o       (apu_master_op_o),
    .apu_master_operands_o (apu_master_operands_o),
    .apu_master_flags_o    (apu_master_flags_o),
    .apu_master_valid_i    (apu_master_valid_i),
    .apu_master_result_i   (apu_master_result_i),
    .apu_master_flags_i    (apu_master_flags_i),
    .wb_valid_o            (wb_valid_o),
    .wb_waddr_o            (wb_waddr_o),
    .wb_result_o           (wb_result_o),
    .fflags_we_o           (fflags_we_o),
    .fflags_o              (fflags_o),
    .busy_o                (busy_o),
    .protocol_err_o        (protocol_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One directed cycle: inputs, expected comb outputs before the edge and
  // expected registered outputs after it.
  typedef struct {
    string    name;
    bit       rst_n;
    bit       en;
    bit [2:0] typ;
    bit [5:0] waddr;
    bit [5:0] rs0;
    bit       rs0_v;
    bit       gnt;
    bit       vld;
    bit       e_req;
    bit       e_stall;
    bit       e_wbv;
    bit [5:0] e_wba;
    bit       e_busy;
    bit       e_perr;
  } vec_t;

  function automatic vec_t mk(input string nm, input bit rst_n, input bit en, input int typ,
                              input int wa, input int rs, input bit rsv, input bit gnt,
                              input bit vld, input bit e_req, input bit e_stall, input bit e_wbv,
                              input int e_wba, input bit e_busy, input bit e_perr);
    vec_t v;
    v.name = nm;  v.rst_n = rst_n; v.en = en;  v.typ = 3'(typ); v.waddr = 6'(wa);
    v.rs0 = 6'(rs); v.rs0_v = rsv; v.gnt = gnt; v.vld = vld;
    v.e_req = e_req; v.e_stall = e_stall; v.e_wbv = e_wbv; v.e_wba = 6'(e_wba);
    v.e_busy = e_busy; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic apply_row(input vec_t v, input int idx);
    logic [31:0] res;
    logic [4:0]  ff;
    res = 32'hD00D_0000 + 32'(idx);
    ff  = 5'(idx);
    rst_ni                = v.rst_n;
    enable_i              = v.en;
    apu_type_i            = v.typ;
    apu_waddr_i           = v.waddr;
    apu_read_regs_i       = {6'd0, 6'd0, v.rs0};
    apu_read_regs_valid_i = {2'b00, v.rs0_v};
    apu_master_gnt_i      = v.gnt;
    apu_master_valid_i    = v.vld;
    apu_master_result_i   = res;
    apu_master_flags_i    = ff;
    #2;
    check({v.name, ".req"},   32'(apu_master_req_o), 32'(v.e_req));
    check({v.name, ".stall"}, 32'(stall_o),          32'(v.e_stall));
    @(posedge clk_i); #1;
    check({v.name, ".wb_valid"},  32'(wb_valid_o),     32'(v.e_wbv));
    check({v.name, ".fflags_we"}, 32'(fflags_we_o),    32'(v.e_wbv));
    check({v.name, ".busy"},      32'(busy_o),         32'(v.e_busy));
    check({v.name, ".perr"},      32'(protocol_err_o), 32'(v.e_perr));
    if (v.e_wbv) begin
      check({v.name, ".wb_waddr"},  32'(wb_waddr_o), 32'(v.e_wba));
      check({v.name, ".wb_result"}, wb_result_o,     res);
      check({v.name, ".fflags"},    32'(fflags_o),   32'(ff));
    end else if (!v.rst_n) begin
      check({v.name, ".rst_waddr"},  32'(wb_waddr_o), 32'd0);
      check({v.name, ".rst_result"}, wb_result_o,     32'd0);
      check({v.name, ".rst_fflags"}, 32'(fflags_o),   32'd0);
    end
  endtask

  // Reference model: latency class from the unit type (-1 = iterative).
  function automatic int cls_of(input int t);
    case (t)
      0, 1:    return C_DSP_PIPE_REGS;
      3:       return C_ADDSUB_PIPE_REGS;
      4:       return C_MULT_PIPE_REGS;
      5:       return C_MAC_PIPE_REGS;
      6:       return C_CAST_PIPE_REGS;
      default: return -1;
    endcase
  endfunction

  // Does a pending write to register r block the instruction at decode?
  function automatic bit clash(input int r);
    bit c;
    c = (int'(apu_waddr_i) == r);
    for (int s = 0; s < 3; s++)
      if (apu_read_regs_valid_i[s] && int'(apu_read_regs_i[s]) == r) c = 1'b1;
    return c;
  endfunction

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  q[$];
    int  mcls, mwba, cls;
    bit  mwbv, mperr, hold, hz, can, e_req, e_stall;
    logic [31:0] mres;
    logic [4:0]  mff;

    // Reset state; enable held high to see stall follow it under reset.
    rst_ni = 1'b0; enable_i = 1'b1; apu_type_i = 3'd3; apu_op_i = '0;
    apu_operands_i = '0; apu_flags_i = '0; apu_waddr_i = '0; apu_read_regs_i = '0;
    apu_read_regs_valid_i = '0; apu_master_gnt_i = 1'b1; apu_master_valid_i = 1'b0;
    apu_master_result_i = '0; apu_master_flags_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset.req",       32'(apu_master_req_o), 32'd0);
    check("reset.stall",     32'(stall_o),          32'd1);
    check("reset.wb_valid",  32'(wb_valid_o),       32'd0);
    check("reset.fflags_we", 32'(fflags_we_o),      32'd0);
    check("reset.busy",      32'(busy_o),           32'd0);
    check("reset.perr",      32'(protocol_err_o),   32'd0);
    check("reset.wb_waddr",  32'(wb_waddr_o),       32'd0);
    check("reset.wb_result", wb_result_o,           32'd0);
    check("reset.fflags",    32'(fflags_o),         32'd0);

    //        name  rst en typ   wa rs rv gnt vld  req stl wbv wba busy perr
    // Back-to-back ADDSUB, results two cycles after each issue.
    tbl.push_back(mk("A0", 1, 1, T_ADD, 5, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("A1", 1, 1, T_ADD, 6, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("A2", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 5, 1, 0));
    tbl.push_back(mk("A3", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 6, 1, 0));
    tbl.push_back(mk("A4", 1, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    // MAC behind an in-flight ADDSUB waits for the pipe to drain.
    tbl.push_back(mk("B0", 1, 1, T_ADD, 1, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("B1", 1, 1, T_MAC, 2, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("B2", 1, 1, T_MAC, 2, 0, 0, 1, 1,  0, 1, 1, 1, 1, 0));
    tbl.push_back(mk("B3", 1, 1, T_MAC, 2, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("B4", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 2, 1, 0));
    tbl.push_back(mk("B5", 1, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    // DIVSQRT runs alone: a second DIVSQRT and then an ADDSUB both wait.
    tbl.push_back(mk("C0", 1, 1, T_DIV, 3, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("C1", 1, 1, T_DIV, 4, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("C2", 1, 1, T_DIV, 4, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("C3", 1, 1, T_DIV, 4, 0, 0, 1, 1,  0, 1, 1, 3, 1, 0));
    tbl.push_back(mk("C4", 1, 1, T_DIV, 4, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("C5", 1, 1, T_ADD, 9, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("C6", 1, 1, T_ADD, 9, 0, 0, 1, 1,  0, 1, 1, 4, 1, 0));
    tbl.push_back(mk("C7", 1, 1, T_ADD, 9, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("C8", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 9, 1, 0));
    tbl.push_back(mk("C9", 1, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    // RAW on x7: blocked while in flight and during its writeback cycle.
    tbl.push_back(mk("D0", 1, 1, T_MUL, 7, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("D1", 1, 1, T_MUL, 8, 7, 1, 1, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("D2", 1, 1, T_MUL, 8, 7, 1, 1, 1,  0, 1, 1, 7, 1, 0));
    tbl.push_back(mk("D3", 1, 1, T_MUL, 8, 7, 1, 1, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("D4", 1, 1, T_MUL, 8, 7, 1, 1, 0,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("D5", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 8, 1, 0));
    tbl.push_back(mk("D6", 1, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    // Fill four, fifth stalls even across a retire; then push+pop at count 3 with wrap.
    tbl.push_back(mk("E0", 1, 1, T_ADD, 10, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("E1", 1, 1, T_ADD, 11, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("E2", 1, 1, T_ADD, 12, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("E3", 1, 1, T_ADD, 13, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk("E4", 1, 1, T_ADD, 14, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("E5", 1, 1, T_ADD, 14, 0, 0, 1, 1, 0, 1, 1, 10, 1, 0));
    tbl.push_back(mk("E6", 1, 1, T_ADD, 14, 0, 0, 1, 1, 1, 0, 1, 11, 1, 0));
    tbl.push_back(mk("E7", 1, 1, T_ADD, 15, 0, 0, 1, 1, 1, 0, 1, 12, 1, 0));
    tbl.push_back(mk("E8", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 13, 1, 0));
    tbl.push_back(mk("E9", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 1, 14, 1, 0));
    tbl.push_back(mk("E10", 1, 0, 0,    0, 0, 0, 0, 1,  0, 0, 1, 15, 1, 0));
    tbl.push_back(mk("E11", 1, 0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    // Stray result -> sticky error; reset mid-flight clears everything;
    // a result from the flushed pipe then raises the error again.
    tbl.push_back(mk("F0", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("F1", 1, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("F2", 1, 1, T_ADD, 20, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk("F3", 1, 1, T_ADD, 21, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk("F4", 1, 1, T_ADD, 22, 0, 0, 1, 1, 1, 0, 1, 20, 1, 1));
    tbl.push_back(mk("F5", 0, 1, T_ADD, 23, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("F6", 1, 0, 0,     0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("F7", 0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("F8", 1, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply_row(tbl[i], i);

    // Randomized run against the queue model (state is clean after F8).
    mcls = 0; mwbv = 1'b0; mwba = 0; mres = '0; mff = '0; mperr = 1'b0; hold = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!hold) begin
        enable_i    = ($urandom_range(0, 3) != 0);
        apu_type_i  = 3'($urandom_range(0, 7));
        apu_op_i    = 3'($urandom);
        apu_flags_i = 15'($urandom);
        apu_waddr_i = 6'($urandom_range(0, 7));
        for (int s = 0; s < 3; s++) begin
          apu_operands_i[s]  = $urandom;
          apu_read_regs_i[s] = 6'($urandom_range(0, 7));
        end
        apu_read_regs_valid_i = 3'($urandom);
      end
      apu_master_gnt_i    = ($urandom_range(0, 3) != 0);
      apu_master_valid_i  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      apu_master_result_i = $urandom;
      apu_master_flags_i  = 5'($urandom);
      #2;
      hz = 1'b0;
      foreach (q[k]) if (clash(q[k])) hz = 1'b1;
      if (mwbv && clash(mwba)) hz = 1'b1;
      cls     = cls_of(int'(apu_type_i));
      can     = !hz && (q.size() < N) && (q.size() == 0 || (cls == mcls && mcls != -1));
      e_req   = enable_i && can;
      e_stall = enable_i && !(e_req && apu_master_gnt_i);
      check($sformatf("rnd%0d.req", c),   32'(apu_master_req_o), 32'(e_req));
      check($sformatf("rnd%0d.stall", c), 32'(stall_o),          32'(e_stall));
      check($sformatf("rnd%0d.type", c),  32'(apu_master_type_o), 32'(apu_type_i));
      check($sformatf("rnd%0d.op", c),    32'(apu_master_op_o),   32'(apu_op_i));
      check($sformatf("rnd%0d.dflags", c), 32'(apu_master_flags_o), 32'(apu_flags_i));
      for (int s = 0; s < 3; s++)
        check($sformatf("rnd%0d.opnd%0d", c, s), apu_master_operands_o[s], apu_operands_i[s]);
      mwbv = 1'b0;
      if (apu_master_valid_i) begin
        if (q.size() > 0) begin
          mwbv = 1'b1;
          mwba = q.pop_front();
          mres = apu_master_result_i;
          mff  = apu_master_flags_i;
        end else begin
          mperr = 1'b1;
        end
      end
      if (e_req && apu_master_gnt_i) begin
        q.push_back(int'(apu_waddr_i));
        mcls = cls;
      end
      hold = e_stall;
      @(posedge clk_i); #1;
      check($sformatf("rnd%0d.wb_valid", c),  32'(wb_valid_o),     32'(mwbv));
      check($sformatf("rnd%0d.fflags_we", c), 32'(fflags_we_o),    32'(mwbv));
      check($sformatf("rnd%0d.busy", c),      32'(busy_o),         32'(q.size() != 0 || mwbv));
      check($sformatf("rnd%0d.perr", c),      32'(protocol_err_o), 32'(mperr));
      if (mwbv) begin
        check($sformatf("rnd%0d.wb_waddr", c),  32'(wb_waddr_o), 32'(mwba));
        check($sformatf("rnd%0d.wb_result", c), wb_result_o,     mres);
        check($sformatf("rnd%0d.fflags", c),    32'(fflags_o),   32'(mff));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
